adder_seq_ctrl: RTL and testbench
=================================

# adder_seq_ctrl

Multi-cycle sequencer that computes an M-bit sum (M = N·K) by time-sharing a single N-bit ripple adder (`adder_N`) over K clock cycles. Each cycle adds one N-bit chunk, least-significant chunk first, and registers the inter-chunk carry. A start/busy/done handshake lets datapath logic request wide additions without instantiating K adders. It sits between operand-producing logic and the shared `adder_N` instance.

## Interface
- `N`, 4, chunk width in bits; the width of the shared `adder_N`.
- `K`, 2, number of chunks, K ≥ 1.
- `M`, N*K, operand and result width; derived, do not override.

- `clk`  in  1  sole clock; rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new addition. Sampled only in IDLE or DONE.
- `A`  in  M  operand A. Sampled on the accepting edge.
- `B`  in  M  operand B. Sampled on the accepting edge.
- `Cin`  in  1  carry into chunk 0. Sampled on the accepting edge.
- `busy`  out  1  high while chunks are being processed (RUN).
- `done`  out  1  one-cycle pulse; result valid.
- `Y`  out  M  registered sum; held until the next completion.
- `Cout`  out  1  registered carry out of the top chunk.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `start` = 1 → RUN.
  - On that edge: latch A and B into operand registers, Cin into the carry register, and clear the chunk index to 0.
- **RUN**
  - Each cycle, drive `adder_N` with chunk[idx] of the latched A and B, plus the carry register.
  - On the edge: write the adder sum into partial-result chunk[idx], write the adder carry-out into the carry register, and increment idx.
  - When idx = K−1 on the edge: copy the completed partial result and final carry into Y and Cout, then go to DONE.
- **DONE**
  - `done` = 1 for exactly this cycle.
  - `start` = 1 → RUN, with operands latched as in IDLE (back-to-back operation).
  - Otherwise → IDLE.
- `start` during RUN is ignored. It is not queued.
- Y and Cout change only on the edge entering DONE. Partial results are never visible on Y.
- Arithmetic: {Cout,Y} = A + B + Cin, computed modulo 2^(M+1). No overflow flag is produced.
- The chunk index is ⌈log2 K⌉ bits wide (minimum 1). It never exceeds K−1.
- K = 1: RUN lasts one cycle; behaviour is otherwise identical.

## Timing
- Reset values: state = IDLE, `busy` = 0, `done` = 0, Y = 0, Cout = 0. Carry register, index and partial result are also cleared.
- Reset has priority over all other inputs. Reset asserted during RUN or DONE aborts the operation. No `done` is produced for it, and Y/Cout return to 0.
- Latency, with `start` sampled high at edge E0:
  - `busy` is high for the K cycles following E0.
  - `done` is high in the cycle following edge E0+K.
  - Y and Cout are valid from that cycle onward.
- Throughput: one addition per K+1 cycles.
- `adder_N` is purely combinational inside the RUN cycle. Its path is one N-bit ripple.
- `busy` and `done` are decoded from registered state. There is no combinational path from `start` to any output.

## Structure
- Package `adder_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} adder_state_t`
  - default `N` and `K` localparams
- One sub-module instance: the existing `adder_N #(.N(N))`, with port order (Y, Cout, A, B, Cin). The sequencer instantiates exactly one.
- Chunk selection uses indexed part-selects (`[idx*N +: N]`).
- Expected size: about 120–160 lines of RTL.

## Test plan
All scenarios use N = 4, K = 2.
- **Reset:** hold `reset` for 2 cycles → `busy` = 0, `done` = 0, Y = 8'h00, Cout = 0.
- **Chunk carry propagation:** A = 8'h0F, B = 8'h01, Cin = 0, 1-cycle `start` →
  - `busy` high for 2 cycles, then `done` pulse.
  - Y = 8'h10, Cout = 0.
- **Full overflow:** A = 8'hFF, B = 8'h01, Cin = 0 → Y = 8'h00, Cout = 1.
- **Carry in:**
  - A = 8'h00, B = 8'h00, Cin = 1 → Y = 8'h01, Cout = 0.
  - A = 8'h7F, B = 8'h80, Cin = 1 → Y = 8'h00, Cout = 1.
- **Handshake edge cases:**
  - `start` pulsed mid-RUN with different operands → ignored; result matches the first request.
  - `start` held high through DONE → second operation begins immediately. Exactly one `done` every 3 cycles.
- **Reset mid-operation:** assert `reset` in the second RUN cycle →
  - next cycle: IDLE, no `done`, Y = 0.
  - a following request A = 8'h12, B = 8'h34 → Y = 8'h46.
- **Exhaustive sweep:** all 2^16 A/B pairs with Cin = 0 → assert {Cout,Y} == A + B at every `done`.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and default sizing for the chunked adder sequencer.
package adder_pkg;
    localparam int ADD_N = 4;
    localparam int ADD_K = 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} adder_state_t;
endpackage

// File: rtl/adder_N.sv
// N-bit combinational ripple-carry adder shared by the sequencer.
module adder_N #(
    parameter int N = 4
) (
    output logic [N-1:0] Y,
    output logic         Cout,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin
);
    logic c;

    always_comb begin
        Y = '0;
        c = Cin;
        for (int i = 0; i < N; i++) begin
            Y[i] = A[i] ^ B[i] ^ c;
            c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
        end
        Cout = c;
    end
endmodule

// File: rtl/adder_seq_ctrl.sv
// Computes an M-bit sum over K cycles by feeding one N-bit chunk per cycle
// (LSB chunk first) through a single shared adder_N, with a registered carry.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one chunk added per cycle, idx counts 0..K-1
// DONE  | result on Y/Cout, done pulse; start here chains the next add
module adder_seq_ctrl
    import adder_pkg::*;
#(
    parameter  int N = ADD_N,
    parameter  int K = ADD_K,
    localparam int M = N * K
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    input  logic         Cin,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] Y,
    output logic         Cout
);
    localparam int              IW       = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0]   IDX_LAST = IW'(K - 1);

    adder_state_t  state, state_d;
    logic [M-1:0]  op_a, op_b, part, part_next;
    logic          carry_q;
    logic [IW-1:0] idx;
    logic [N-1:0]  chunk_sum;
    logic          chunk_cout;
    logic          accept;
    logic          last_chunk;

    adder_N #(.N(N)) u_adder (
        .Y    (chunk_sum),
        .Cout (chunk_cout),
        .A    (op_a[idx*N +: N]),
        .B    (op_b[idx*N +: N]),
        .Cin  (carry_q)
    );

    assign accept     = start && ((state == IDLE) || (state == DONE));
    assign last_chunk = (idx == IDX_LAST);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_chunk) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Final chunk is merged here so Y gets the full result on the same edge.
    always_comb begin
        part_next                = part;
        part_next[idx*N +: N]    = chunk_sum;
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            op_a    <= '0;
            op_b    <= '0;
            part    <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            Y       <= '0;
            Cout    <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                op_a    <= A;
                op_b    <= B;
                carry_q <= Cin;
                idx     <= '0;
            end else if (state == RUN) begin
                part    <= part_next;
                carry_q <= chunk_cout;
                if (last_chunk) begin
                    idx  <= '0;
                    Y    <= part_next;
                    Cout <= chunk_cout;
                end else begin
                    idx  <= idx + IW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Randomized self-checking bench for adder_seq_ctrl (N=4, K=2) against an
// arithmetic reference model with cycle-count expectations.
module tb_adder_seq_ctrl;
    localparam int N = 4;
    localparam int K = 2;
    localparam int M = N * K;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [M-1:0] A, B;
    logic         Cin;
    logic         busy, done;
    logic [M-1:0] Y;
    logic         Cout;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [M:0]   last_res = '0;

    adder_seq_ctrl #(.N(N), .K(K)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .Y     (Y),
        .Cout  (Cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [M:0] ref_sum(input logic [M-1:0] a, input logic [M-1:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + (M+1)'(cin);
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after done.
    task automatic run_op(input logic [M-1:0] a, input logic [M-1:0] b, input logic cin, input bit poke);
        logic [M:0] exp;
        int cyc, bcnt;
        exp   = ref_sum(a, b, cin);
        A     = a;
        B     = b;
        Cin   = cin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        bcnt  = 0;
        A     = M'($urandom);
        B     = M'($urandom);
        Cin   = 1'($urandom);
        if (poke) begin
            start = 1'b1;
            A     = ~a;
            B     = b ^ 8'h5A;
            Cin   = ~cin;
        end
        while (!done && cyc < 20) begin
            if (busy) bcnt++;
            chk("y_hold", {31'b0, Cout, Y} >> 0, 32'(last_res));
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(K + 1));
        chk("busy_cnt", 32'(bcnt), 32'(K));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("sum", 32'({Cout, Y}), 32'(exp));
        last_res = exp;
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("y_after", 32'({Cout, Y}), 32'(exp));
    endtask

    // start held high: a new operation is accepted every K+1 edges.
    task automatic back_to_back(input int reps);
        logic [M:0] exp_q[$];
        logic [M-1:0] a, b;
        logic cin;
        int ndone = 0;
        start = 1'b1;
        for (int c = 0; c < (K + 1) * reps; c++) begin
            if (c % (K + 1) == 0) begin
                a = M'($urandom);
                b = M'($urandom);
                cin = 1'($urandom);
                A = a; B = b; Cin = cin;
                exp_q.push_back(ref_sum(a, b, cin));
            end else begin
                A = M'($urandom); B = M'($urandom); Cin = 1'($urandom);
            end
            @(negedge clk);
            chk("b2b_done", 32'(done), 32'(c % (K + 1) == K));
            if (done) begin
                ndone++;
                if (exp_q.size() > 0) begin
                    last_res = exp_q.pop_front();
                    chk("b2b_sum", 32'({Cout, Y}), 32'(last_res));
                end
            end
        end
        start = 1'b0;
        chk("b2b_count", 32'(ndone), 32'(reps));
        @(negedge clk);
        chk("b2b_idle", 32'({busy, done}), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        Cin   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_y", 32'(Y), 32'h00);
        chk("rst_cout", 32'(Cout), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(8'h0F, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b0);
        run_op(8'h7F, 8'h80, 1'b1, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        run_op(8'h3C, 8'h45, 1'b0, 1'b1);
        run_op(8'hA5, 8'h5A, 1'b1, 1'b1);

        back_to_back(6);

        run_op(8'h0F, 8'h01, 1'b0, 1'b0);
        A = 8'hAA; B = 8'h11; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mid_busy1", 32'(busy), 32'd1);
        @(negedge clk);
        chk("mid_busy2", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_y", 32'({Cout, Y}), 32'd0);
        reset = 1'b0;
        last_res = '0;
        @(negedge clk);
        chk("mid_rst_idle", 32'({busy, done}), 32'd0);
        run_op(8'h12, 8'h34, 1'b0, 1'b0);
        chk("post_rst_sum", 32'(Y), 32'h46);

        for (int i = 0; i < 2000; i++)
            run_op(M'($urandom), M'($urandom), 1'($urandom_range(0, 3) == 0), $urandom_range(0, 7) == 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
